wb_grf_commit: RTL and testbench

- Consumer end of the WB->ID write-back interface in the P6 five-stage MIPS pipeline.
- Takes the registered WB-stage controls and data, selects the write-back value and commits it to a 32x32 general register file.
- Serves the two ID-stage read ports with same-cycle write-through bypass.
- Keeps a commit counter and last-commit trace registers for the bench and debug.

---
 rtl/wb_grf_commit_if.sv | 31 +++
 rtl/wb_grf_commit.sv | 89 ++++++++
 tb/tb_wb_grf_commit.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_grf_commit_if.sv
// WB-stage write-back bus feeding the register-file commit block.
// The master side is the WB pipeline register; the slave side is the GRF.
interface wb_grf_commit_if;
    logic        RegWrite_W;
    logic [1:0]  Mem2Reg_W;
    logic [4:0]  WRegAdd_W;
    logic [31:0] result_W;
    logic [31:0] memdata_W;
    logic [31:0] PC8_W;
    logic [31:0] PC_W;

    modport master (
        output RegWrite_W,
        output Mem2Reg_W,
        output WRegAdd_W,
        output result_W,
        output memdata_W,
        output PC8_W,
        output PC_W
    );

    modport slave (
        input RegWrite_W,
        input Mem2Reg_W,
        input WRegAdd_W,
        input result_W,
        input memdata_W,
        input PC8_W,
        input PC_W
    );
endinterface

// File: rtl/wb_grf_commit.sv
// WB-stage commit into the 32x32 GPR file, with same-cycle write-through
// bypass on both ID read ports plus a commit counter and last-commit trace.
module wb_grf_commit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    wb_grf_commit_if.slave    wb,
    input  logic [4:0]        RA1_D,
    input  logic [4:0]        RA2_D,
    output logic [31:0]       RD1_D,
    output logic [31:0]       RD2_D,
    output logic [CNT_W-1:0]  commit_cnt,
    output logic [31:0]       last_pc,
    output logic [4:0]        last_addr,
    output logic [31:0]       last_data,
    output logic              bad_sel
);

    logic [31:0] wd;
    logic        we;
    logic        sel_reserved;
    logic [31:0] gpr [32];

    always_comb begin
        wd = '0;
        case (wb.Mem2Reg_W)
            2'd0:    wd = wb.result_W;
            2'd1:    wd = wb.memdata_W;
            2'd2:    wd = wb.PC8_W;
            default: wd = '0;
        endcase
    end

    assign sel_reserved = (wb.Mem2Reg_W == 2'd3);
    assign we = wb.RegWrite_W && (wb.WRegAdd_W != 5'd0) && !sel_reserved;

    // Entry 0 is only ever cleared, so it stays a constant zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                gpr[i] <= '0;
            end
        end else if (we) begin
            gpr[wb.WRegAdd_W] <= wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_cnt <= '0;
            last_pc    <= RESET_PC;
            last_addr  <= '0;
            last_data  <= '0;
            bad_sel    <= 1'b0;
        end else begin
            if (we) begin
                commit_cnt <= commit_cnt + CNT_W'(1);
                last_pc    <= wb.PC_W;
                last_addr  <= wb.WRegAdd_W;
                last_data  <= wd;
            end
            if (wb.RegWrite_W && sel_reserved) begin
                bad_sel <= 1'b1;
            end
        end
    end

    // Reset also gates the bypass so nothing leaks through while held.
    always_comb begin
        RD1_D = gpr[RA1_D];
        if (reset || (RA1_D == 5'd0)) begin
            RD1_D = '0;
        end else if (we && (RA1_D == wb.WRegAdd_W)) begin
            RD1_D = wd;
        end
    end

    always_comb begin
        RD2_D = gpr[RA2_D];
        if (reset || (RA2_D == 5'd0)) begin
            RD2_D = '0;
        end else if (we && (RA2_D == wb.WRegAdd_W)) begin
            RD2_D = wd;
        end
    end

endmodule

// File: tb/tb_wb_grf_commit.sv
// Bench for wb_grf_commit: directed scenarios plus random traffic against
// an array-based register-file model; a CNT_W=4 twin checks counter wrap.
module tb_wb_grf_commit;

    logic        clk;
    logic        reset;
    logic [4:0]  RA1_D, RA2_D;
    logic [31:0] RD1_D, RD2_D;
    logic [31:0] commit_cnt;
    logic [31:0] last_pc;
    logic [4:0]  last_addr;
    logic [31:0] last_data;
    logic        bad_sel;

    logic [31:0] rd1_n, rd2_n;
    logic [3:0]  cnt4;
    logic [31:0] last_pc_n;
    logic [4:0]  last_addr_n;
    logic [31:0] last_data_n;
    logic        bad_sel_n;

    int total;
    int bad;

    wb_grf_commit_if bus ();

    wb_grf_commit #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .wb(bus.slave),
        .RA1_D(RA1_D), .RA2_D(RA2_D), .RD1_D(RD1_D), .RD2_D(RD2_D),
        .commit_cnt(commit_cnt), .last_pc(last_pc), .last_addr(last_addr),
        .last_data(last_data), .bad_sel(bad_sel)
    );

    wb_grf_commit #(.RESET_PC(32'h0000_3000), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .wb(bus.slave),
        .RA1_D(RA1_D), .RA2_D(RA2_D), .RD1_D(rd1_n), .RD2_D(rd2_n),
        .commit_cnt(cnt4), .last_pc(last_pc_n), .last_addr(last_addr_n),
        .last_data(last_data_n), .bad_sel(bad_sel_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain register array and trace variables.
    logic [31:0] m_gpr [32];
    int unsigned m_cnt;
    logic [31:0] m_last_pc;
    logic [4:0]  m_last_addr;
    logic [31:0] m_last_data;
    logic        m_bad;

    function automatic logic [31:0] m_wd();
        case (bus.Mem2Reg_W)
            2'd0:    return bus.result_W;
            2'd1:    return bus.memdata_W;
            2'd2:    return bus.PC8_W;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_we();
        return bus.RegWrite_W && bus.WRegAdd_W != 0 && bus.Mem2Reg_W != 2'd3;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        if (reset || ra == 0) return 32'h0;
        if (m_we() && ra == bus.WRegAdd_W) return m_wd();
        return m_gpr[ra];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
        m_cnt = 0;
        m_last_pc = 32'h0000_3000;
        m_last_addr = 5'd0;
        m_last_data = 32'h0;
        m_bad = 1'b0;
    endtask

    task automatic drive(input bit rw, input bit [1:0] sel, input bit [4:0] a,
                         input bit [31:0] res, input bit [31:0] mem,
                         input bit [31:0] pc8, input bit [31:0] pc);
        bus.RegWrite_W = rw;
        bus.Mem2Reg_W  = sel;
        bus.WRegAdd_W  = a;
        bus.result_W   = res;
        bus.memdata_W  = mem;
        bus.PC8_W      = pc8;
        bus.PC_W       = pc;
    endtask

    // Take one rising edge with current inputs and advance the model.
    task automatic step();
        @(posedge clk);
        if (m_we()) begin
            m_gpr[bus.WRegAdd_W] = m_wd();
            m_cnt++;
            m_last_pc   = bus.PC_W;
            m_last_addr = bus.WRegAdd_W;
            m_last_data = m_wd();
        end
        if (bus.RegWrite_W && bus.Mem2Reg_W == 2'd3) m_bad = 1'b1;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk); drive(1, 0, 3, 32'h1111_0003, 0, 0, 32'h0000_3100); step();
        @(negedge clk); drive(1, 1, 8, 0, 32'h2222_0008, 0, 32'h0000_3104); step();
        @(negedge clk); drive(1, 0, 8, 32'h7777_7777, 0, 0, 32'h0000_3108);
        RA1_D = 5'd3; RA2_D = 5'd8;
        #2 reset = 1'b1;
        #1;
        total++; if (RD1_D !== 32'h0) begin bad++; $display("FAIL reset_rd1 got=%h want=%h", RD1_D, 32'h0); end
        total++; if (RD2_D !== 32'h0) begin bad++; $display("FAIL reset_rd2 got=%h want=%h", RD2_D, 32'h0); end
        total++; if (commit_cnt !== 32'h0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", commit_cnt); end
        total++; if (last_pc !== 32'h0000_3000) begin bad++; $display("FAIL reset_last_pc got=%h want=%h", last_pc, 32'h0000_3000); end
        total++; if (last_addr !== 5'd0 || last_data !== 32'h0 || bad_sel !== 1'b0) begin
            bad++; $display("FAIL reset_trace got=%0d/%h/%b want=0/0/0", last_addr, last_data, bad_sel);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int r = 1; r < 32; r++) begin
            @(negedge clk);
            RA1_D = 5'(r); RA2_D = 5'(32 - r);
            #1;
            total++; if (RD1_D !== 32'h0 || RD2_D !== 32'h0) begin
                bad++; $display("FAIL post_reset_reg%0d got=%h/%h want=0/0", r, RD1_D, RD2_D);
            end
        end
    endtask

    task automatic test_source_select();
        apply_reset();
        @(negedge clk); drive(1, 0, 5, 32'hDEAD_BEEF, 32'h1, 32'h2, 32'h0000_3200); step();
        @(negedge clk); drive(1, 1, 6, 32'h3, 32'h1234_5678, 32'h4, 32'h0000_3204); step();
        @(negedge clk); drive(1, 2, 31, 32'h5, 32'h6, 32'h0000_3008, 32'h0000_3000); step();
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);
        RA1_D = 5'd5; RA2_D = 5'd6;
        #1;
        total++; if (RD1_D !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sel0_read got=%h want=%h", RD1_D, 32'hDEAD_BEEF); end
        total++; if (RD2_D !== 32'h1234_5678) begin bad++; $display("FAIL sel1_read got=%h want=%h", RD2_D, 32'h1234_5678); end
        RA1_D = 5'd31;
        #1;
        total++; if (RD1_D !== 32'h0000_3008) begin bad++; $display("FAIL sel2_read got=%h want=%h", RD1_D, 32'h0000_3008); end
        total++; if (commit_cnt !== 32'd3) begin bad++; $display("FAIL sel_cnt got=%0d want=3", commit_cnt); end
        total++; if (last_addr !== 5'd31) begin bad++; $display("FAIL sel_last_addr got=%0d want=31", last_addr); end
        total++; if (last_pc !== 32'h0000_3000) begin bad++; $display("FAIL sel_last_pc got=%h want=%h", last_pc, 32'h0000_3000); end
        total++; if (last_data !== 32'h0000_3008) begin bad++; $display("FAIL sel_last_data got=%h want=%h", last_data, 32'h0000_3008); end
    endtask

    task automatic test_zero_reg();
        @(negedge clk); drive(1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_3300);
        RA1_D = 5'd0; RA2_D = 5'd0;
        #1;
        total++; if (RD1_D !== 32'h0) begin bad++; $display("FAIL zero_bypass got=%h want=0", RD1_D); end
        step();
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        total++; if (RD1_D !== 32'h0) begin bad++; $display("FAIL zero_store got=%h want=0", RD1_D); end
        total++; if (commit_cnt !== 32'(m_cnt)) begin bad++; $display("FAIL zero_cnt got=%0d want=%0d", commit_cnt, m_cnt); end
        total++; if (last_pc !== m_last_pc || last_addr !== m_last_addr || last_data !== m_last_data) begin
            bad++; $display("FAIL zero_trace got=%h/%0d/%h want=%h/%0d/%h", last_pc, last_addr, last_data, m_last_pc, m_last_addr, m_last_data);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk); drive(1, 0, 7, 32'h1111_2222, 0, 0, 32'h0000_3400); step();
        @(negedge clk); drive(0, 0, 7, 32'hA5A5_A5A5, 0, 0, 32'h0000_3404);
        RA1_D = 5'd7; RA2_D = 5'd7;
        #1;
        total++; if (RD1_D !== 32'h1111_2222 || RD2_D !== 32'h1111_2222) begin
            bad++; $display("FAIL bypass_off got=%h/%h want=%h", RD1_D, RD2_D, 32'h1111_2222);
        end
        bus.RegWrite_W = 1'b1;
        #1;
        total++; if (RD1_D !== 32'hA5A5_A5A5 || RD2_D !== 32'hA5A5_A5A5) begin
            bad++; $display("FAIL bypass_on got=%h/%h want=%h", RD1_D, RD2_D, 32'hA5A5_A5A5);
        end
        step();
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        total++; if (RD1_D !== 32'hA5A5_A5A5) begin bad++; $display("FAIL bypass_stored got=%h want=%h", RD1_D, 32'hA5A5_A5A5); end
    endtask

    task automatic test_reserved();
        @(negedge clk); drive(1, 0, 9, 32'h0000_9999, 0, 0, 32'h0000_3500); step();
        @(negedge clk); drive(1, 3, 9, 32'hBAD0_BAD0, 32'hBAD1_BAD1, 32'hBAD2_BAD2, 32'h0000_3504);
        RA1_D = 5'd9; RA2_D = 5'd9;
        #1;
        total++; if (RD1_D !== 32'h0000_9999) begin bad++; $display("FAIL reserved_nobypass got=%h want=%h", RD1_D, 32'h0000_9999); end
        total++; if (bad_sel !== 1'b0) begin bad++; $display("FAIL reserved_early got=%b want=0", bad_sel); end
        step();
        total++; if (bad_sel !== 1'b1) begin bad++; $display("FAIL reserved_flag got=%b want=1", bad_sel); end
        total++; if (commit_cnt !== 32'(m_cnt) || last_pc !== 32'h0000_3500) begin
            bad++; $display("FAIL reserved_nocount got=%0d/%h want=%0d/%h", commit_cnt, last_pc, m_cnt, 32'h0000_3500);
        end
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);
        repeat (10) step();
        total++; if (RD1_D !== 32'h0000_9999) begin bad++; $display("FAIL reserved_store got=%h want=%h", RD1_D, 32'h0000_9999); end
        total++; if (bad_sel !== 1'b1) begin bad++; $display("FAIL reserved_sticky got=%b want=1", bad_sel); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                  $urandom, $urandom, $urandom, $urandom);
            RA1_D = (n % 4 == 0) ? bus.WRegAdd_W : 5'($urandom_range(0, 31));
            RA2_D = 5'($urandom_range(0, 31));
            #1;
            total++; if (RD1_D !== exp_rd(RA1_D)) begin bad++; $display("FAIL rand_rd1 n=%0d ra=%0d got=%h want=%h", n, RA1_D, RD1_D, exp_rd(RA1_D)); end
            total++; if (RD2_D !== exp_rd(RA2_D)) begin bad++; $display("FAIL rand_rd2 n=%0d ra=%0d got=%h want=%h", n, RA2_D, RD2_D, exp_rd(RA2_D)); end
            step();
            total++; if (commit_cnt !== 32'(m_cnt) || cnt4 !== 4'(m_cnt)) begin
                bad++; $display("FAIL rand_cnt n=%0d got=%0d/%0d want=%0d/%0d", n, commit_cnt, cnt4, 32'(m_cnt), 4'(m_cnt));
            end
            total++; if (last_pc !== m_last_pc || last_addr !== m_last_addr || last_data !== m_last_data || bad_sel !== m_bad) begin
                bad++; $display("FAIL rand_trace n=%0d got=%h/%0d/%h/%b want=%h/%0d/%h/%b", n,
                                last_pc, last_addr, last_data, bad_sel, m_last_pc, m_last_addr, m_last_data, m_bad);
            end
        end
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk); drive(1, 0, 5'((i % 31) + 1), $urandom, 0, 0, 32'h0000_3600 + 32'(4 * i));
            step();
        end
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        total++; if (cnt4 !== 4'd1) begin bad++; $display("FAIL wrap_cnt4 got=%0d want=1", cnt4); end
        total++; if (commit_cnt !== 32'd17) begin bad++; $display("FAIL wrap_cnt32 got=%0d want=17", commit_cnt); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        RA1_D = 5'd0;
        RA2_D = 5'd0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        test_reset();
        test_source_select();
        test_zero_reg();
        test_bypass();
        test_reserved();
        test_random();
        test_counter_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
